// File: rtl/pu_hop_rx.sv
// Receive end of the path-parser -> PU hop stream: buffers hops in a circular RAM, emits one descriptor per packet.
// Optional statistics counters are built when PU_HOP_RX_STATS_EN is defined.
`ifndef RESET_SIG
`define RESET_SIG rst
`endif
`ifndef HOP_INFO_NBITS
`define HOP_INFO_NBITS 16
`endif

module pu_hop_rx #(
  parameter int HOP_BUF_DEPTH_NBITS   = 5,
  parameter int HOP_CNT_NBITS         = 4,
  parameter int DESC_FIFO_DEPTH_NBITS = 2
) (
  input  logic                           clk,
  input  logic                           `RESET_SIG,
  input  logic                           pp_pu_hop_valid,
  input  logic [`HOP_INFO_NBITS-1:0]     pp_pu_hop_data,
  input  logic                           pp_pu_hop_sop,
  input  logic                           pp_pu_hop_eop,
  input  logic                           pp_pu_hop_error,
  output logic                           pu_pp_hop_ready,
  output logic                           pu_desc_valid,
  input  logic                           pu_desc_ready,
  output logic [HOP_BUF_DEPTH_NBITS-1:0] pu_desc_start,
  output logic [HOP_CNT_NBITS-1:0]       pu_desc_cnt,
  output logic                           pu_desc_error,
  input  logic [HOP_BUF_DEPTH_NBITS-1:0] pu_hop_raddr,
  output logic [`HOP_INFO_NBITS-1:0]     pu_hop_rdata,
  input  logic                           pu_hop_release,
  input  logic [HOP_CNT_NBITS-1:0]       pu_hop_release_cnt,
  output logic [1:0]                     dbg_state_o
`ifdef PU_HOP_RX_STATS_EN
  ,
  output logic [31:0]                    stat_pkt_cnt,
  output logic [31:0]                    stat_err_cnt,
  output logic [31:0]                    stat_drop_cnt
`endif
);
  localparam int AW  = HOP_BUF_DEPTH_NBITS;
  localparam int CW  = HOP_CNT_NBITS;
  localparam int FW  = DESC_FIFO_DEPTH_NBITS;
  localparam int HW  = `HOP_INFO_NBITS;
  localparam logic [CW-1:0] MAX_HOPS    = '1;
  localparam logic [FW:0]   DFIFO_DEPTH = (FW+1)'(1 << FW);

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DROP = 2'd2} state_e;
  typedef struct packed {
    logic [AW-1:0] start;
    logic [CW-1:0] cnt;
    logic          err;
  } desc_t;

  function automatic desc_t mk_desc(input logic [AW-1:0] s, input logic [CW-1:0] c, input logic e);
    desc_t d;
    d.start = s;
    d.cnt   = c;
    d.err   = e;
    return d;
  endfunction

  state_e        state_q, state_d, st_n;
  logic [AW:0]   wptr_q, wptr_d, wptr_n, fptr_q, fptr_d, pkt_start_q, pkt_start_d, pkt_start_n;
  logic [CW-1:0] hop_cnt_q, hop_cnt_d, hop_cnt_n;
  logic [AW:0]   base, occ, rel;
  logic          beat_wr, p0, p1, idle_proc, np, acc;
  desc_t         d0, d1, nd;

  // Beat decode assumes the beat is taken; registers only apply it when acc is high.
  always_comb begin
    st_n        = state_q;
    wptr_n      = wptr_q;
    pkt_start_n = pkt_start_q;
    hop_cnt_n   = hop_cnt_q;
    base        = wptr_q;
    beat_wr     = 1'b0;
    p0          = 1'b0;
    p1          = 1'b0;
    d0          = '0;
    d1          = '0;
    nd          = '0;
    np          = 1'b0;
    idle_proc   = 1'b0;
    case (state_q)
      IDLE: idle_proc = 1'b1;
      ACTIVE: begin
        if (pp_pu_hop_sop) begin
          // Unexpected sop: abandon the open packet, then treat this beat as a fresh start.
          wptr_n    = pkt_start_q;
          base      = pkt_start_q;
          p0        = 1'b1;
          d0        = mk_desc(pkt_start_q[AW-1:0], '0, 1'b1);
          st_n      = IDLE;
          idle_proc = 1'b1;
        end else if (pp_pu_hop_error) begin
          wptr_n = pkt_start_q;
          p0     = 1'b1;
          d0     = mk_desc(pkt_start_q[AW-1:0], '0, 1'b1);
          st_n   = IDLE;
        end else if (hop_cnt_q == MAX_HOPS) begin
          wptr_n = pkt_start_q;
          if (pp_pu_hop_eop) begin
            p0   = 1'b1;
            d0   = mk_desc(pkt_start_q[AW-1:0], '0, 1'b1);
            st_n = IDLE;
          end else begin
            st_n = DROP;
          end
        end else begin
          beat_wr   = 1'b1;
          wptr_n    = wptr_q + (AW+1)'(1);
          hop_cnt_n = hop_cnt_q + CW'(1);
          if (pp_pu_hop_eop) begin
            p0   = 1'b1;
            d0   = mk_desc(pkt_start_q[AW-1:0], hop_cnt_q + CW'(1), 1'b0);
            st_n = IDLE;
          end
        end
      end
      DROP: begin
        if (pp_pu_hop_eop) begin
          p0   = 1'b1;
          d0   = mk_desc(pkt_start_q[AW-1:0], '0, 1'b1);
          st_n = IDLE;
        end
      end
      default: st_n = IDLE;
    endcase
    if (idle_proc && pp_pu_hop_sop) begin
      if (pp_pu_hop_error) begin
        np = 1'b1;
        nd = mk_desc(base[AW-1:0], '0, 1'b1);
      end else begin
        beat_wr = 1'b1;
        wptr_n  = base + (AW+1)'(1);
        if (pp_pu_hop_eop) begin
          np = 1'b1;
          nd = mk_desc(base[AW-1:0], CW'(1), 1'b0);
        end else begin
          pkt_start_n = base;
          hop_cnt_n   = CW'(1);
          st_n        = ACTIVE;
        end
      end
      if (np) begin
        if (p0) begin
          p1 = 1'b1;
          d1 = nd;
        end else begin
          p0 = 1'b1;
          d0 = nd;
        end
      end
    end
  end

  // Descriptor FIFO (first-word-fall-through); a violating sop may push two entries in one cycle.
  desc_t       dfifo_q [1 << FW];
  logic [FW-1:0] dwr_q, drd_q;
  logic [FW:0]   dcnt_q, need;
  logic          push0, push1, pop, fifo_ok;

  assign need    = (FW+1)'(p0) + (FW+1)'(p1);
  assign fifo_ok = (dcnt_q != DFIFO_DEPTH) && (need <= DFIFO_DEPTH - dcnt_q);
  assign occ     = base - fptr_q;

  // Handshake: a beat transfers on the rising edge where pp_pu_hop_valid and pu_pp_hop_ready are both high;
  // ready never depends on valid, and only beats that need a buffer slot are held off by a full buffer.
  assign pu_pp_hop_ready = ~`RESET_SIG & fifo_ok & (~beat_wr | ~occ[AW]);
  assign acc   = pp_pu_hop_valid & pu_pp_hop_ready;
  assign push0 = acc & p0;
  assign push1 = acc & p1;
  assign pop   = pu_desc_valid & pu_desc_ready;

  always_comb begin
    state_d     = acc ? st_n : state_q;
    wptr_d      = acc ? wptr_n : wptr_q;
    pkt_start_d = acc ? pkt_start_n : pkt_start_q;
    hop_cnt_d   = acc ? hop_cnt_n : hop_cnt_q;
    rel         = pu_hop_release ? {{(AW+1-CW){1'b0}}, pu_hop_release_cnt} : '0;
    // Over-release is clamped so the free pointer never passes the write pointer.
    if (rel > wptr_d - fptr_q) fptr_d = wptr_d;
    else                       fptr_d = fptr_q + rel;
  end

  always_ff @(posedge clk) begin
    if (`RESET_SIG) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      fptr_q      <= '0;
      pkt_start_q <= '0;
      hop_cnt_q   <= '0;
      dwr_q       <= '0;
      drd_q       <= '0;
      dcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      fptr_q      <= fptr_d;
      pkt_start_q <= pkt_start_d;
      hop_cnt_q   <= hop_cnt_d;
      dwr_q       <= dwr_q + FW'(push0) + FW'(push1);
      drd_q       <= drd_q + FW'(pop);
      dcnt_q      <= dcnt_q + (FW+1)'(push0) + (FW+1)'(push1) - (FW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push0) dfifo_q[dwr_q] <= d0;
    if (push1) dfifo_q[dwr_q + FW'(1)] <= d1;
  end

  assign pu_desc_valid = (dcnt_q != '0);
  assign pu_desc_start = pu_desc_valid ? dfifo_q[drd_q].start : '0;
  assign pu_desc_cnt   = pu_desc_valid ? dfifo_q[drd_q].cnt : '0;
  assign pu_desc_error = pu_desc_valid ? dfifo_q[drd_q].err : 1'b0;
  assign dbg_state_o   = state_q;

  logic [HW-1:0] hop_mem_q [1 << AW];

  always_ff @(posedge clk) begin
    if (acc && beat_wr) hop_mem_q[base[AW-1:0]] <= pp_pu_hop_data;
  end

  always_ff @(posedge clk) begin
    if (`RESET_SIG) pu_hop_rdata <= '0;
    else            pu_hop_rdata <= hop_mem_q[pu_hop_raddr];
  end

`ifdef PU_HOP_RX_STATS_EN
  logic       drop_exit;
  logic [1:0] n_good, n_err;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] b);
    logic [32:0] s;
    s = {1'b0, a} + 33'(b);
    return s[32] ? '1 : s[31:0];
  endfunction

  assign drop_exit = acc & pp_pu_hop_eop & ((state_q == DROP) |
                     ((state_q == ACTIVE) & ~pp_pu_hop_sop & ~pp_pu_hop_error & (hop_cnt_q == MAX_HOPS)));
  assign n_good    = 2'(push0 & ~d0.err) + 2'(push1 & ~d1.err);
  assign n_err     = 2'(push0 & d0.err) + 2'(push1 & d1.err) - 2'(drop_exit);

  always_ff @(posedge clk) begin
    if (`RESET_SIG) begin
      stat_pkt_cnt  <= '0;
      stat_err_cnt  <= '0;
      stat_drop_cnt <= '0;
    end else begin
      stat_pkt_cnt  <= sat_add(stat_pkt_cnt, n_good);
      stat_err_cnt  <= sat_add(stat_err_cnt, n_err);
      stat_drop_cnt <= sat_add(stat_drop_cnt, {1'b0, drop_exit});
    end
  end
`endif

endmodule

// File: tb/tb_pu_hop_rx.sv
// Directed + randomized bench for pu_hop_rx; expected descriptors and hop data come from a packet-level model.
`ifndef RESET_SIG
`define RESET_SIG rst
`endif
`ifndef HOP_INFO_NBITS
`define HOP_INFO_NBITS 16
`endif

module tb_pu_hop_rx;
  localparam int AW    = 5;
  localparam int CW    = 4;
  localparam int HW    = `HOP_INFO_NBITS;
  localparam int DW    = AW + CW + 1;
  localparam int MAXH  = 15;
  localparam int DEPTH = 32;

  logic          clk, rst;
  logic          valid, sop, eop, err, ready;
  logic [HW-1:0] data, rdata;
  logic          dvalid, dready, derr;
  logic [AW-1:0] dstart, raddr;
  logic [CW-1:0] dcnt, rel_cnt;
  logic          rel;
  logic [1:0]    dbg_state;
`ifdef PU_HOP_RX_STATS_EN
  logic [31:0]   stat_pkt, stat_err, stat_drop;
`endif

  pu_hop_rx dut (
    .clk                (clk),
    .`RESET_SIG         (rst),
    .pp_pu_hop_valid    (valid),
    .pp_pu_hop_data     (data),
    .pp_pu_hop_sop      (sop),
    .pp_pu_hop_eop      (eop),
    .pp_pu_hop_error    (err),
    .pu_pp_hop_ready    (ready),
    .pu_desc_valid      (dvalid),
    .pu_desc_ready      (dready),
    .pu_desc_start      (dstart),
    .pu_desc_cnt        (dcnt),
    .pu_desc_error      (derr),
    .pu_hop_raddr       (raddr),
    .pu_hop_rdata       (rdata),
    .pu_hop_release     (rel),
    .pu_hop_release_cnt (rel_cnt),
    .dbg_state_o        (dbg_state)
`ifdef PU_HOP_RX_STATS_EN
    ,
    .stat_pkt_cnt       (stat_pkt),
    .stat_err_cnt       (stat_err),
    .stat_drop_cnt      (stat_drop)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: works per packet from the protocol rules; the write pointer only moves on a good packet.
  logic [DW-1:0] exp_q[$];
  logic [HW-1:0] exp_data_q[$];
  logic [HW-1:0] m_hops[$];
  int            m_wptr, m_start;
  bit            m_in, m_drop;

  function automatic void push_desc(input int start, input int cnt, input bit er);
    logic [AW-1:0] s;
    logic [CW-1:0] c;
    s = start[AW-1:0];
    c = cnt[CW-1:0];
    exp_q.push_back({s, c, er});
  endfunction

  function automatic void commit();
    push_desc(m_start, m_hops.size(), 1'b0);
    foreach (m_hops[i]) exp_data_q.push_back(m_hops[i]);
    m_wptr += m_hops.size();
    m_hops.delete();
    m_in = 1'b0;
  endfunction

  function automatic void model_beat(input bit s, input bit e, input bit er, input logic [HW-1:0] d);
    if (m_drop) begin
      if (e) begin
        push_desc(m_start, 0, 1'b1);
        m_drop = 1'b0;
      end
      return;
    end
    if (m_in) begin
      if (s) begin
        push_desc(m_start, 0, 1'b1);
        m_in = 1'b0;
        m_hops.delete();
      end else if (er) begin
        push_desc(m_start, 0, 1'b1);
        m_in = 1'b0;
        m_hops.delete();
        return;
      end else if (m_hops.size() == MAXH) begin
        m_in = 1'b0;
        m_hops.delete();
        if (e) push_desc(m_start, 0, 1'b1);
        else   m_drop = 1'b1;
        return;
      end else begin
        m_hops.push_back(d);
        if (e) commit();
        return;
      end
    end
    if (!s) return;
    if (er) begin
      push_desc(m_wptr, 0, 1'b1);
      return;
    end
    m_start = m_wptr;
    m_hops.delete();
    m_hops.push_back(d);
    m_in = 1'b1;
    if (e) commit();
  endfunction

  // All driver tasks start and end on a falling edge.
  task automatic send_beat(input bit s, input bit e, input bit er, input logic [HW-1:0] d);
    int w = 0;
    valid = 1'b1; sop = s; eop = e; err = er; data = d;
    #1;
    while (ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (ready !== 1'b1) begin
      check("beat_accept_timeout", ready, 1);
      valid = 1'b0;
      @(negedge clk);
      return;
    end
    @(posedge clk);
    model_beat(s, e, er, d);
    @(negedge clk);
    valid = 1'b0; sop = 1'b0; eop = 1'b0; err = 1'b0;
  endtask

  task automatic probe_ready(input string tag, input bit s, input bit e, input bit exp);
    valid = 1'b1; sop = s; eop = e; err = 1'b0; data = HW'($urandom);
    #1;
    check(tag, ready, exp);
    valid = 1'b0; sop = 1'b0; eop = 1'b0;
    @(negedge clk);
  endtask

  task automatic pop_check(output int got_cnt);
    logic [DW-1:0] e;
    int w = 0;
    int estart, ecnt;
    while (dvalid !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("desc_valid", dvalid, 1);
    e = exp_q.pop_front();
    check("desc_fields", {dstart, dcnt, derr}, e);
    dready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dready = 1'b0;
    estart = int'(e[DW-1:CW+1]);
    ecnt   = int'(e[CW:1]);
    for (int i = 0; i < ecnt; i++) begin
      raddr = AW'((estart + i) % DEPTH);
      @(posedge clk);
      @(negedge clk);
      check("hop_rdata", rdata, exp_data_q.pop_front());
    end
    got_cnt = ecnt;
  endtask

  task automatic release_n(input int n);
    rel = 1'b1;
    rel_cnt = CW'(n);
    @(posedge clk);
    @(negedge clk);
    rel = 1'b0;
    rel_cnt = '0;
  endtask

  task automatic drain();
    int c;
    while (exp_q.size() > 0) begin
      pop_check(c);
      if (c > 0) release_n(c);
    end
  endtask

  task automatic send_pkt(input int len);
    for (int i = 0; i < len; i++) send_beat(i == 0, i == len - 1, 1'b0, HW'($urandom));
  endtask

  initial begin
    int c, len, mid, errpos;
    rst = 1'b1; valid = 1'b0; sop = 1'b0; eop = 1'b0; err = 1'b0; data = '0;
    dready = 1'b0; raddr = '0; rel = 1'b0; rel_cnt = '0;
    m_wptr = 0; m_start = 0; m_in = 1'b0; m_drop = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 0);
    check("rst_desc_valid", dvalid, 0);
    check("rst_desc_fields", {dstart, dcnt, derr}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    @(negedge clk);

    // 3-hop packet, descriptor appears right after eop
    check("t1_no_desc_yet", dvalid, 0);
    send_beat(1, 0, 0, 16'hA);
    send_beat(0, 0, 0, 16'hB);
    check("t1_active", dbg_state, 1);
    send_beat(0, 1, 0, 16'hC);
    check("t1_valid_after_eop", dvalid, 1);
    check("t1_desc_const", {dstart, dcnt, derr}, {5'd0, 4'd3, 1'b0});
    drain();

    // upstream error on eop, then a good packet reusing the rewound pointer
    send_beat(1, 0, 0, 16'h11);
    send_beat(0, 0, 0, 16'h12);
    send_beat(0, 1, 1, 16'h13);
    check("t2_back_idle", dbg_state, 0);
    send_pkt(2);
    drain();

    // overlong packet drops after 15 hops
    send_beat(1, 0, 0, HW'($urandom));
    for (int i = 0; i < 16; i++) send_beat(0, 0, 0, HW'($urandom));
    check("t3_dropping", dbg_state, 2);
    send_beat(0, 1, 0, HW'($urandom));
    drain();

    // fill the whole buffer, then free 4 entries and write across the wrap
    send_pkt(15);
    send_pkt(15);
    send_pkt(2);
    probe_ready("t4_full_blocks", 1, 0, 0);
    pop_check(c);
    release_n(4);
    probe_ready("t4_resume", 1, 0, 1);
    send_beat(1, 0, 0, 16'h4A);
    send_beat(0, 1, 0, 16'h4B);
    release_n(c - 4);
    drain();

    // sop while a packet is open
    send_beat(1, 0, 0, 16'h5A);
    send_beat(1, 1, 0, 16'h5B);
    drain();

    // descriptor FIFO full back-pressures the hop stream
    for (int i = 0; i < 4; i++) send_pkt(1);
    probe_ready("t6_fifo_full", 1, 1, 0);
    pop_check(c);
    release_n(c);
    probe_ready("t6_resume", 1, 1, 1);
    drain();

    // randomized packets: good, error, overlong, mid-packet sop, stray beats
    for (int p = 0; p < 40; p++) begin
      len    = $urandom_range(1, 20);
      mid    = (len > 2 && $urandom_range(0, 4) == 0) ? $urandom_range(1, len - 2) : -1;
      errpos = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len - 1) : -1;
      if ($urandom_range(0, 5) == 0) send_beat(0, $urandom_range(0, 1), 0, HW'($urandom));
      for (int i = 0; i < len; i++)
        send_beat(i == 0 || i == mid, i == len - 1, i == errpos, HW'($urandom));
      drain();
    end
    check("end_idle", dbg_state, 0);
    check("end_no_desc", dvalid, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
